// File: rtl/conv_job_csr.sv
// AXI4-Lite CSR front end for the conv NPU: a staging descriptor is pushed into a job FIFO,
// issued to the engine over valid/ready, and completion/error status raises a maskable interrupt.
module conv_job_csr #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int QDEPTH     = 4,
  parameter int DESC_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            s_axi_awaddr,
  input  logic [2:0]                   s_axi_awprot,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_W-1:0]            s_axi_wdata,
  input  logic [DATA_W/8-1:0]          s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [ADDR_W-1:0]            s_axi_araddr,
  input  logic [2:0]                   s_axi_arprot,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [DATA_W-1:0]            s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic                         job_valid,
  input  logic                         job_ready,
  output logic [DESC_WORDS*DATA_W-1:0] job_desc,
  input  logic                         eng_done,
  input  logic                         eng_err,
  output logic                         irq
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(QDEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WIDX_W = ADDR_W - 2;
  localparam int SIDX_W = (DESC_WORDS > 1) ? $clog2(DESC_WORDS) : 1;
  localparam int DESC_W = DESC_WORDS * DATA_W;

  localparam logic [WIDX_W-1:0] IDX_CTRL     = WIDX_W'(16);
  localparam logic [WIDX_W-1:0] IDX_STATUS   = WIDX_W'(17);
  localparam logic [WIDX_W-1:0] IDX_IRQ_STAT = WIDX_W'(18);
  localparam logic [WIDX_W-1:0] IDX_DONE_CNT = WIDX_W'(19);
  localparam logic [WIDX_W-1:0] IDX_STAGE_LIM = WIDX_W'(DESC_WORDS);

  logic [DATA_W-1:0] stage [DESC_WORDS];
  logic [DESC_W-1:0] stage_flat;
  logic [DESC_W-1:0] fifo_mem [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              running, exception, irq_en;
  logic [2:0]        irq_stat;
  logic [31:0]       done_cnt;

  logic              wr_hs, ar_hs;
  logic [WIDX_W-1:0] wr_idx, rd_idx;
  logic              wr_ctrl, wr_irq_stat, push_req, push_ok, push_drop, flush, pop;
  logic              full, empty, done_ev, err_ev;
  logic [2:0]        irq_clr, irq_set;
  logic [15:0]       status;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_ok;

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Handshakes are gated by rst so every ready reads 0 while reset is held.
  assign wr_hs         = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~rst;
  assign ar_hs         = s_axi_arvalid & ~s_axi_rvalid & ~rst;
  assign s_axi_awready = wr_hs;
  assign s_axi_wready  = wr_hs;
  assign s_axi_arready = ar_hs;
  assign wr_idx        = s_axi_awaddr[ADDR_W-1:2];
  assign rd_idx        = s_axi_araddr[ADDR_W-1:2];

  assign full      = (count == CNT_W'(QDEPTH));
  assign empty     = (count == '0);
  assign job_valid = ~empty & ~running;
  assign job_desc  = fifo_mem[rd_ptr];
  assign pop       = job_valid & job_ready;

  assign wr_ctrl     = wr_hs & (wr_idx == IDX_CTRL) & s_axi_wstrb[0];
  assign wr_irq_stat = wr_hs & (wr_idx == IDX_IRQ_STAT) & s_axi_wstrb[0];
  assign push_req    = wr_ctrl & s_axi_wdata[0];
  assign flush       = wr_ctrl & s_axi_wdata[2];
  // A full queue still accepts a push when the same cycle frees a slot (pop or flush).
  assign push_ok     = push_req & (~full | pop | flush);
  assign push_drop   = push_req & ~push_ok;

  assign done_ev = eng_done & running;
  assign err_ev  = eng_err & running;
  assign irq_set = {push_drop, err_ev, done_ev};
  assign irq_clr = s_axi_wdata[2:0] & {3{wr_irq_stat}};

  assign status = {8'(count), 3'b000, full, empty, running, exception, running | ~empty};

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    stage_flat = '0;
    for (int i = 0; i < DESC_WORDS; i++) stage_flat[i*DATA_W +: DATA_W] = stage[i];
  end

  always_comb begin
    rd_mux = '0;
    if (rd_idx < IDX_STAGE_LIM) rd_mux = stage[rd_idx[SIDX_W-1:0]];
    else begin
      case (rd_idx)
        IDX_CTRL:     rd_mux = DATA_W'({irq_en, 1'b0});
        IDX_STATUS:   rd_mux = DATA_W'(status);
        IDX_IRQ_STAT: rd_mux = DATA_W'(irq_stat);
        IDX_DONE_CNT: rd_mux = DATA_W'(done_cnt);
        default:      rd_mux = '0;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; its contents are only meaningful while job_valid says so.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= stage_flat;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DESC_WORDS; i++) stage[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      running      <= 1'b0;
      exception    <= 1'b0;
      irq_en       <= 1'b0;
      irq_stat     <= '0;
      done_cnt     <= '0;
      irq          <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= 2'b00;
      s_axi_rdata  <= '0;
    end else begin
      if (wr_hs && wr_idx < IDX_STAGE_LIM) begin
        for (int b = 0; b < STRB_W; b++)
          if (s_axi_wstrb[b]) stage[wr_idx[SIDX_W-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
      if (wr_ctrl) irq_en <= s_axi_wdata[1];

      // Flush empties the queue before a push from the same write lands.
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= CNT_W'(push_ok);
      end else begin
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      end
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);

      if (pop) running <= 1'b1;
      else if (done_ev || err_ev) running <= 1'b0;

      exception <= (exception & ~irq_clr[1]) | err_ev;
      irq_stat  <= (irq_stat & ~irq_clr) | irq_set;
      done_cnt  <= done_cnt + 32'(done_ev);
      irq       <= irq_en & (|irq_stat);

      if (wr_hs) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= push_drop ? 2'b10 : 2'b00;
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end

      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rresp  <= 2'b00;
        s_axi_rdata  <= rd_mux;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule
